// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard controller state encoding and the
// reset-time constants used by the pipeline control blocks.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        WAIT_FETCH = 1'b1
    } hz_state_t;

    localparam int unsigned REG_AW  = 5;
    localparam logic [31:0] PC_ADDR = 32'h8000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/redirect controller. A taken branch that meets an
// in-flight fetch parks its target until that fetch returns and is discarded.
module pipeline_hazard_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = pipeline_hazard_ctrl_pkg::PC_ADDR,
    parameter int unsigned           REG_AW     = pipeline_hazard_ctrl_pkg::REG_AW,
    parameter int unsigned           CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_br_taken,
    input  logic [ADDR_WIDTH-1:0] ex_br_target,
    input  logic                  ex_mem_read,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  if_busy,
    input  logic                  if_ack,
    input  logic                  mem_busy,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  fetch_discard,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  redirect_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    import pipeline_hazard_ctrl_pkg::*;

    hz_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  br, lu;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        br = ex_br_taken & ~mem_busy;
        lu = ex_mem_read & (ex_rd != '0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        fetch_discard  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = pend_pc_q;
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;

        if (!reset_n) begin
            redirect_pc = PC_ADDR;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                    end else if (br) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (!if_busy || if_ack) begin
                            fetch_discard  = if_ack;
                            redirect_valid = 1'b1;
                            redirect_pc    = ex_br_target;
                        end else begin
                            // PC must not move while the wrong-path fetch is still out.
                            stall_pc  = 1'b1;
                            pend_pc_d = ex_br_target;
                            state_d   = WAIT_FETCH;
                        end
                    end else if (lu) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (if_busy && !if_ack) begin
                        stall_pc    = 1'b1;
                        flush_if_id = 1'b1;
                    end
                end
                WAIT_FETCH: begin
                    stall_pc     = 1'b1;
                    flush_if_id  = 1'b1;
                    stall_id_ex  = mem_busy;
                    stall_ex_mem = mem_busy;
                    if (if_ack) begin
                        fetch_discard  = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc_q;
                        state_d        = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            pend_pc_q <= PC_ADDR;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (redirect_valid),
        .cnt_o   (redirect_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (stall_pc & ~redirect_valid),
        .cnt_o   (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// expected controls; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int unsigned CW     = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    // Expected control vector bit positions
    localparam logic [7:0] SPC   = 8'h80;
    localparam logic [7:0] SIFID = 8'h40;
    localparam logic [7:0] SIDEX = 8'h20;
    localparam logic [7:0] SEXM  = 8'h10;
    localparam logic [7:0] FIFID = 8'h08;
    localparam logic [7:0] FIDEX = 8'h04;
    localparam logic [7:0] FD    = 8'h02;
    localparam logic [7:0] RV    = 8'h01;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ex_br_taken = 1'b0;
    logic [31:0]   ex_br_target = '0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic [4:0]    id_rs1 = '0;
    logic [4:0]    id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic          if_busy = 1'b0;
    logic          if_ack = 1'b0;
    logic          mem_busy = 1'b0;
    logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic          flush_if_id, flush_id_ex, fetch_discard, redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] redirect_cnt, stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .ADDR_WIDTH (32),
        .PC_ADDR    (RST_PC),
        .REG_AW     (5),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .if_busy        (if_busy),
        .if_ack         (if_ack),
        .mem_busy       (mem_busy),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .stall_ex_mem   (stall_ex_mem),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .fetch_discard  (fetch_discard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_cnt   (redirect_cnt),
        .stall_cnt      (stall_cnt)
    );

    typedef struct {
        string         name;
        logic [7:0]    ctl;
        logic          chk_pc;
        logic [31:0]   pc;
        logic [CW-1:0] rc;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] m_rc = '0;
    logic [CW-1:0] m_sc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus plus its expected response.
    task automatic cyc(input string name, input logic rst, input logic br, input logic [31:0] tgt,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic ifb, input logic ack,
                       input logic mb, input logic [7:0] ctl, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n      = ~rst;
        ex_br_taken  = br;
        ex_br_target = tgt;
        ex_mem_read  = mr;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        if_busy      = ifb;
        if_ack       = ack;
        mem_busy     = mb;
        if (rst) begin
            m_rc = '0;
            m_sc = '0;
        end
        e.name   = name;
        e.ctl    = ctl;
        e.chk_pc = rst | ctl[0];
        e.pc     = pc;
        e.rc     = m_rc;
        e.sc     = m_sc;
        sb.push_back(e);
        if (!rst) begin
            if (ctl[0] && (m_rc != '1)) m_rc = m_rc + 1'b1;
            if (ctl[7] && !ctl[0] && (m_sc != '1)) m_sc = m_sc + 1'b1;
        end
    endtask

    task automatic idle(input string name);
        cyc(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, " ctl"}, {24'h0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  flush_if_id, flush_id_ex, fetch_discard, redirect_valid}, {24'h0, mon_e.ctl});
            if (mon_e.chk_pc) check({mon_e.name, " redirect_pc"}, redirect_pc, mon_e.pc);
            check({mon_e.name, " redirect_cnt"}, 32'(redirect_cnt), 32'(mon_e.rc));
            check({mon_e.name, " stall_cnt"}, 32'(stall_cnt), 32'(mon_e.sc));
        end
    end

    always @(negedge clk) begin
        if (reset_n && (dut.state_q == WAIT_FETCH))
            assert (!ex_br_taken) else $error("ex_br_taken driven while waiting on fetch");
    end

    initial begin
        // Reset with busy inputs: every control stays low.
        cyc("reset_a", 1, 1, 32'h1234, 1, 5, 5, 1, 0, 0, 1, 0, 0, 8'h00, RST_PC);
        cyc("reset_b", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00, RST_PC);
        idle("idle0");

        cyc("br_nobusy", 0, 1, 32'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 0, 0, FIFID|FIDEX|RV, 32'h8000_0040);
        idle("br_after");

        cyc("lu_rs2", 0, 0, 0, 1, 5, 0, 0, 5, 1, 0, 0, 0, SPC|SIFID|FIDEX, 0);
        idle("lu_after");
        cyc("lu_x0", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc("lu_rs1", 0, 0, 0, 1, 7, 7, 1, 3, 1, 0, 0, 0, SPC|SIFID|FIDEX, 0);
        cyc("lu_nouse", 0, 0, 0, 1, 7, 7, 0, 3, 1, 0, 0, 0, 8'h00, 0);
        cyc("lu_noload", 0, 0, 0, 0, 7, 7, 1, 7, 1, 0, 0, 0, 8'h00, 0);

        cyc("br_busy", 0, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID|FIDEX, 0);
        cyc("wf_1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID, 0);
        cyc("wf_2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID, 0);
        cyc("wf_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, SPC|FIFID|FD|RV, 32'h8000_0100);
        idle("wf_after");

        cyc("br_busy_ack", 0, 1, 32'h8000_0140, 0, 0, 0, 0, 0, 0, 1, 1, 0, FIFID|FIDEX|FD|RV, 32'h8000_0140);
        idle("bba_after");

        for (int i = 0; i < 4; i++)
            cyc("mb_br", 0, 1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 1, SPC|SIFID|SIDEX|SEXM, 0);
        cyc("mb_drop", 0, 1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 0, FIFID|FIDEX|RV, 32'h8000_0200);
        idle("mb_after");

        cyc("br_busy2", 0, 1, 32'h8000_0280, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID|FIDEX, 0);
        cyc("wf_mb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, SPC|FIFID|SIDEX|SEXM, 0);
        cyc("wf_mb_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, SPC|FIFID|SIDEX|SEXM|FD|RV, 32'h8000_0280);
        idle("wfmb_after");

        cyc("br_lu", 0, 1, 32'h8000_0300, 1, 5, 0, 0, 5, 1, 0, 0, 0, FIFID|FIDEX|RV, 32'h8000_0300);
        idle("brlu_after");

        cyc("if_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID, 0);
        cyc("if_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0);
        cyc("lu_ifb", 0, 0, 0, 1, 5, 0, 0, 5, 1, 1, 0, 0, SPC|SIFID|FIDEX, 0);

        // Reset while a redirect is pending: it must be forgotten.
        cyc("br_busy3", 0, 1, 32'h8000_0380, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID|FIDEX, 0);
        cyc("wf_3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID, 0);
        cyc("rst_wf", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, RST_PC);
        cyc("late_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0);

        for (int i = 0; i < 18; i++)
            cyc("sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SPC|FIFID, 0);
        idle("sat_end");
        idle("sat_end2");

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
